// File: rtl/reg_dump_reader_if.sv
// Word-stream channel carrying a framed register dump from reader to sink.
interface reg_dump_reader_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register array through a combinational read port and streams
// header, NREG register words and an XOR checksum over a valid/ready channel.
module reg_dump_reader #(
  parameter int               WIDTH  = 16,
  parameter int               NREG   = 4,
  parameter int               AW     = 2,
  parameter logic [WIDTH-1:0] HEADER = 16'hA55A
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [AW-1:0]        rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  reg_dump_reader_if.master    stream,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  typedef enum logic [2:0] {IDLE, HEAD, FETCH, SEND, SUM} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
  logic             busy_reg, busy_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             xfer;

  assign xfer = valid_reg & stream.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      sum_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      sum_reg   <= sum_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    sum_next   = sum_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (start) begin
        data_next  = HEADER;
        valid_next = 1'b1;
        sum_next   = '0;
        idx_next   = '0;
        state_next = HEAD;
      end
      HEAD: if (xfer) begin
        valid_next = 1'b0;
        addr_next  = '0;
        state_next = FETCH;
      end
      // rd_addr has been stable for a full cycle by the time it is sampled here
      FETCH: begin
        data_next  = rd_data;
        sum_next   = sum_reg ^ rd_data;
        valid_next = 1'b1;
        state_next = SEND;
      end
      SEND: if (xfer) begin
        if (idx_reg == LAST_IDX) begin
          data_next  = sum_reg;
          last_next  = 1'b1;
          state_next = SUM;
        end else begin
          idx_next   = idx_reg + 1'b1;
          addr_next  = idx_reg + 1'b1;
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end
      SUM: if (xfer) begin
        valid_next = 1'b0;
        last_next  = 1'b0;
        addr_next  = '0;
        cnt_next   = cnt_reg + 8'd1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  assign rd_addr          = addr_reg;
  assign stream.out_data  = data_reg;
  assign stream.out_valid = valid_reg;
  assign stream.out_last  = last_reg;
  assign busy             = busy_reg;
  assign frame_cnt        = cnt_reg;

endmodule
